// File: rtl/lcd_num_assembler.sv
// lcd_num_assembler: drains a standard byte FIFO, parses {SYNC,ch} + payload frames,
// converts the payload to packed BCD with a sequential double-dabble and keeps the
// latest value per channel. Bad headers and out-of-range channels bump err_cnt.
module lcd_num_assembler #(
  parameter int         NUM_CH         = 4,
  parameter int         BYTES_PER_WORD = 2,
  parameter int         BIN_W          = 12,
  parameter int         DIGITS         = 4,
  parameter logic [3:0] SYNC           = 4'hA,
  localparam int        CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [7:0]                 fifo_dout,
  output logic                       fifo_rd_en,
  output logic [NUM_CH*DIGITS*4-1:0] bcd_all,
  output logic                       bcd_valid,
  output logic [CH_W-1:0]            bcd_ch,
  output logic                       overflow,
  output logic [7:0]                 err_cnt,
  output logic                       busy
);

  localparam int DW    = DIGITS * 4;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10_minus1(DIGITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CAP   = 3'd1,
    S_CHECK = 3'd2,
    S_CONV  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rd_en_nxt;
  logic [2:0]        idx;
  logic [3:0]        ch_q;
  logic [BIN_W-1:0]  word;
  logic [BIN_W-1:0]  word_in;
  logic [BIN_W-1:0]  bin_sr;
  logic [DW-1:0]     acc;
  logic [DW-1:0]     acc_adj;
  logic [DW+BIN_W-1:0] dd_shift;
  logic              ovf_q;
  logic [CNT_W-1:0]  cnt;

  logic hdr_ok;
  logic last_byte;
  logic ch_bad;
  logic too_big;
  logic err_hit;

  assign hdr_ok    = (fifo_dout[7:4] == SYNC);
  assign last_byte = (idx == 3'(BYTES_PER_WORD));
  assign ch_bad    = ({1'b0, ch_q} >= 5'(NUM_CH));
  assign too_big   = (64'(word) > MAX_VAL);
  assign err_hit   = ((state == S_CAP) && (idx == 3'd0) && !hdr_ok) ||
                     ((state == S_CHECK) && ch_bad);

  // Payload bytes arrive MSB first; only the low BIN_W bits of the word are kept.
  generate
    if (BIN_W > 8) begin : g_wide
      assign word_in = {word[BIN_W-9:0], fifo_dout};
    end else begin : g_narrow
      assign word_in = fifo_dout[BIN_W-1:0];
    end
  endgenerate

  // Double-dabble step: add 3 to every digit >= 5, then shift the whole
  // {bcd, binary} pair left by one so the binary MSB enters digit 0.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[d*4 +: 4] >= 4'd5) acc_adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
    end
    dd_shift = {acc_adj, bin_sr} << 1;
  end

  // State register and the registered FIFO read strobe.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      fifo_rd_en <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_rd_en <= rd_en_nxt;
    end
  end

  // Next-state logic. The read for the next byte is issued on the edge that
  // returns to S_IDLE, so a steady FIFO costs two cycles per byte while still
  // keeping at most one byte in flight.
  always_comb begin
    state_nxt = state;
    rd_en_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_rd_en) state_nxt = S_CAP;
        else            rd_en_nxt = !fifo_empty;
      end
      S_CAP: begin
        if ((idx != 3'd0) && last_byte) begin
          state_nxt = S_CHECK;
        end else begin
          state_nxt = S_IDLE;
          rd_en_nxt = !fifo_empty;
        end
      end
      S_CHECK: begin
        if (ch_bad) begin
          state_nxt = S_IDLE;
          rd_en_nxt = !fifo_empty;
        end else if (too_big) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt == CNT_W'(BIN_W - 1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        rd_en_nxt = !fifo_empty;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs derived from the current state.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Frame parsing and conversion datapath.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      idx    <= 3'd0;
      ch_q   <= 4'd0;
      word   <= '0;
      bin_sr <= '0;
      acc    <= '0;
      ovf_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_CAP: begin
          if (idx == 3'd0) begin
            if (hdr_ok) begin
              ch_q <= fifo_dout[3:0];
              idx  <= 3'd1;
            end
          end else begin
            word <= word_in;
            idx  <= last_byte ? 3'd0 : idx + 3'd1;
          end
        end
        S_CHECK: begin
          if (!ch_bad) begin
            if (too_big) begin
              acc   <= {DIGITS{4'h9}};
              ovf_q <= 1'b1;
            end else begin
              acc    <= '0;
              bin_sr <= word;
              ovf_q  <= 1'b0;
              cnt    <= '0;
            end
          end
        end
        S_CONV: begin
          acc    <= dd_shift[DW+BIN_W-1:BIN_W];
          bin_sr <= dd_shift[BIN_W-1:0];
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Saturating error counter for dropped headers and out-of-range channels.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_hit && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // Result write-back: update one channel slot and pulse bcd_valid.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      bcd_all   <= '0;
      bcd_valid <= 1'b0;
      bcd_ch    <= '0;
      overflow  <= 1'b0;
    end else begin
      bcd_valid <= (state == S_DONE);
      if (state == S_DONE) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_q == 4'(c)) bcd_all[c*DW +: DW] <= acc;
        end
        bcd_ch   <= ch_q[CH_W-1:0];
        overflow <= ovf_q;
      end
    end
  end

endmodule

// File: doc/lcd_num_assembler.md
Name: lcd_num_assembler

Overview:
- Parametrised successor to the single-channel distance unpacker in the LCD display path. Runs in the sys_clk (pixel clock) domain.
- Drains a standard (non-FWFT) byte FIFO, parses framed multi-channel words, and converts each word to packed BCD with a sequential double-dabble.
- Holds the latest BCD value per channel for the lcd_array renderer.
- Adds what the old path lacked: header/channel framing with resync, configurable word width and digit count, overflow saturation, and an error counter.

Parameters:
- NUM_CH, 4: number of channels, 1..16; CH_W = max(1, clog2(NUM_CH)).
- BYTES_PER_WORD, 2: payload bytes per frame, MSB first, 1..4.
- BIN_W, 12: low bits of the assembled payload that are converted; BIN_W <= 8*BYTES_PER_WORD.
- DIGITS, 4: BCD digits per channel, 1..8; MAX = 10^DIGITS - 1.
- SYNC, 4'hA: required upper nibble of a header byte.

Ports:
- sys_clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  8  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read strobe, registered
- bcd_all  out  NUM_CH*DIGITS*4  latest BCD per channel; channel c occupies [c*DIGITS*4 +: DIGITS*4]
- bcd_valid  out  1  one-cycle pulse when a channel slot updates
- bcd_ch  out  CH_W  channel updated with bcd_valid
- overflow  out  1  qualified by bcd_valid: value exceeded MAX and was saturated
- err_cnt  out  8  saturating count of bad headers and out-of-range channels
- busy  out  1  high whenever state != S_IDLE

Behaviour:
- Reset: fifo_rd_en=0, bcd_all=0, bcd_valid=0, bcd_ch=0, overflow=0, err_cnt=0, busy=0; state=S_IDLE, byte index=0 (expect header).
- Frame format: header {SYNC, ch[3:0]}, then BYTES_PER_WORD payload bytes.

States:
- S_IDLE: when fifo_empty=0, set fifo_rd_en=1 for exactly one cycle, then go to S_CAP. No new read is issued until the state returns to S_IDLE, so at most one byte is in flight.
- S_CAP: sample fifo_dout.
  - Index 0 (header): if the upper nibble != SYNC, increment err_cnt, keep index 0, return to S_IDLE. This drops the byte and resyncs. Otherwise latch ch, set index=1, return to S_IDLE.
  - Payload byte: shift it into the word (word = {word[..], byte}). If this is not the last payload byte, index++ and return to S_IDLE. On the last byte, index=0 and go to S_CHECK.
  - Payload bytes are never checked for SYNC.
- S_CHECK:
  - ch >= NUM_CH: increment err_cnt, discard the frame, go to S_IDLE.
  - word[BIN_W-1:0] > MAX: load all-9 digits, set the ovf flag, go to S_DONE.
  - Otherwise: clear the BCD accumulator, load the shift register, and go to S_CONV.
- S_CONV: BIN_W cycles of double-dabble. Each cycle, add 3 to every digit >= 5, then shift left 1 with the binary MSB entering digit 0. After the BIN_W-th cycle, go to S_DONE.
- S_DONE: write the DIGITS*4-bit result into slot ch of bcd_all, set bcd_ch=ch, overflow=ovf, bcd_valid=1 (registered), go to S_IDLE. Other slots are unchanged.
- bcd_valid is cleared the following cycle.

Latency (fifo_rd_en of the last payload byte in cycle n):
- S_CAP in n+1, S_CHECK in n+2.
- Convert path: bcd_valid high in cycle n+BIN_W+4.
- Saturate path: bcd_valid high in cycle n+4.
- FIFO gaps: any number of empty cycles between bytes of a frame is legal; the partial frame is held indefinitely.
- Byte cost: at best 2 cycles per byte.
- err_cnt saturates at 8'hFF.
- Reset during any state: immediate return to reset values, and the partial frame or conversion is lost. fifo_rd_en goes low asynchronously. A byte already popped from the FIFO is lost.
- fifo_rd_en is never asserted while fifo_empty=1 was sampled in the issuing cycle.

Test Plan:
- Defaults. Push A1,0F,FF → bcd_valid once at n+16, bcd_ch=1, overflow=0, bcd_all[31:16]=16'h4095; other slots stay 0.
- Push 55,A0,12,34 → err_cnt=1; ch0 slot=16'h0564 (0x234); exactly one bcd_valid.
- Push A7,00,05 with NUM_CH=4 → err_cnt=1, no bcd_valid, bcd_all unchanged. A following A2,00,05 gives slot2=16'h0005.
- DIGITS=3. Push A0,03,E8 (1000) → bcd_valid at n+4, overflow=1, slot0=12'h999. Then A0,03,E7 → slot0=12'h999, overflow=0.
- Defaults. Feed A3, wait 50 empty cycles, 00, wait 7, 2A → slot3=16'h0042; fifo_rd_en pulses exactly 3 times, each one cycle wide.
- Assert rst mid-S_CONV → all outputs zero next cycle. Then A1,00,07 decodes normally: slot1=16'h0007.
